// File: rtl/pmu_cmd_tx.sv
// pmu_cmd_tx: host-side serial command transmitter for the PMU port.
// Shifts instr+payload MSB-first on sdo/sen, then optionally captures a response word from sdi.
`timescale 1ns/1ps
module pmu_cmd_tx #(
    parameter int INSTR_W    = 4,
    parameter int DATA_W     = 128,
    parameter int RESP_W     = 32,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [INSTR_W-1:0] cmd_instr,
    input  logic [DATA_W-1:0]  cmd_data,
    input  logic               cmd_rd,
    output logic               sdo,
    output logic               sen,
    input  logic               sdi,
    output logic               rsp_valid,
    output logic [RESP_W-1:0]  rsp_data,
    output logic               done,
    output logic               busy
);
    localparam int N    = INSTR_W + DATA_W;
    localparam int MAX1 = N > GAP_CYCLES ? N : GAP_CYCLES;
    localparam int MAXV = MAX1 > RESP_W ? MAX1 : RESP_W;
    localparam int CW   = $clog2(MAXV + 1);
    localparam logic [CW-1:0] SHIFT_LD = CW'(N - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CAP_LD   = CW'(RESP_W - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, GAP, CAP, FIN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N-1:0]      sh_q, sh_d;
    logic [RESP_W-1:0] cap_q, cap_d, rsp_data_q, rsp_data_d;
    logic              rd_q, rd_d;
    logic              sdo_q, sdo_d, sen_q, sen_d, ready_q, ready_d;
    logic              done_q, done_d, rsp_valid_q, rsp_valid_d;
    logic              last;

    assign last = cnt_q == '0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = last ? cnt_q : cnt_q - 1'b1;
        sh_d       = sh_q;
        cap_d      = cap_q;
        rsp_data_d = rsp_data_q;
        rd_d       = rd_q;
        unique case (state_q)
            IDLE: if (cmd_valid) begin
                state_d = SHIFT;
                cnt_d   = SHIFT_LD;
                sh_d    = {cmd_instr, cmd_data};
                rd_d    = cmd_rd;
            end
            SHIFT: begin
                sh_d = sh_q << 1;
                if (last) begin
                    state_d = GAP_CYCLES > 0 ? GAP : (rd_q ? CAP : FIN);
                    cnt_d   = GAP_CYCLES > 0 ? GAP_LD : CAP_LD;
                end
            end
            GAP: if (last) begin
                state_d = rd_q ? CAP : FIN;
                cnt_d   = CAP_LD;
            end
            CAP: begin
                cap_d = {cap_q[RESP_W-2:0], sdi};
                if (last) begin
                    state_d    = FIN;
                    rsp_data_d = cap_d;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // outputs are decoded from the next state so they appear registered in step with it
        sen_d       = state_d == SHIFT;
        sdo_d       = sen_d & sh_d[N-1];
        ready_d     = state_d == IDLE;
        done_d      = state_d == FIN;
        rsp_valid_d = (state_d == FIN) & rd_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            rd_q        <= 1'b0;
            sdo_q       <= 1'b0;
            sen_q       <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            cap_q       <= cap_d;
            rsp_data_q  <= rsp_data_d;
            rd_q        <= rd_d;
            sdo_q       <= sdo_d;
            sen_q       <= sen_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = ~ready_q;
    assign sdo       = sdo_q;
    assign sen       = sen_q;
    assign done      = done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_pmu_cmd_tx.sv
// tb_pmu_cmd_tx: table-driven bench for pmu_cmd_tx with a frame/response scoreboard.
// A second instance covers the zero-gap, short-response configuration.
`timescale 1ns/1ps
module tb_pmu_cmd_tx;
    localparam int N   = 132;
    localparam int GAP = 2;

    typedef struct {
        logic [3:0]   instr;
        logic [127:0] data;
        logic         rd;
        logic [31:0]  rsp;
        logic         keep;
        int           exp_done;
    } vec_t;

    logic         clk, rst;
    logic         cmd_valid, cmd_ready, cmd_rd, sdo, sen, sdi, rsp_valid, done, busy;
    logic [3:0]   cmd_instr;
    logic [127:0] cmd_data;
    logic [31:0]  rsp_data;

    logic         v6, rdy6, rd6, sdo6, sen6, sdi6, rv6, done6, busy6;
    logic [3:0]   i6;
    logic [127:0] d6;
    logic [7:0]   rsp6;

    int           n_tests, n_fail;
    logic         exp_bits[$];
    logic [31:0]  exp_rsp[$];
    logic [31:0]  last_rsp;
    vec_t         vt[6];

    pmu_cmd_tx u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_instr(cmd_instr), .cmd_data(cmd_data), .cmd_rd(cmd_rd),
        .sdo(sdo), .sen(sen), .sdi(sdi), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .done(done), .busy(busy)
    );

    pmu_cmd_tx #(.RESP_W(8), .GAP_CYCLES(0)) u_g0 (
        .clk(clk), .rst(rst), .cmd_valid(v6), .cmd_ready(rdy6),
        .cmd_instr(i6), .cmd_data(d6), .cmd_rd(rd6),
        .sdo(sdo6), .sen(sen6), .sdi(sdi6), .rsp_valid(rv6),
        .rsp_data(rsp6), .done(done6), .busy(busy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drives one command and checks every cycle up to and including FIN.
    task automatic run_cmd(input vec_t v, input bit after_keep, input int abort_k);
        logic [N-1:0] fr;
        logic         exp_sen, exp_sdo;
        int           waited;
        fr = {v.instr, v.data};
        for (int i = N - 1; i >= 0; i--) exp_bits.push_back(fr[i]);
        if (v.rd) exp_rsp.push_back(v.rsp);
        cmd_instr = v.instr;
        cmd_data  = v.data;
        cmd_rd    = v.rd;
        cmd_valid = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            exp_bits.delete();
            exp_rsp.delete();
            cmd_valid = 1'b0;
            return;
        end
        if (after_keep) chk("b2b_accept_wait", waited, 1);
        for (int k = 1; k <= v.exp_done; k++) begin
            @(negedge clk);
            if (k == 1 && !v.keep) cmd_valid = 1'b0;
            if (k == 10 && v.keep) begin
                cmd_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
                cmd_instr = 4'($urandom());
                cmd_rd    = ~cmd_rd;
            end
            if (k == abort_k) begin
                rst = 1'b0;
                #1;
                chk("abort_sen_sdo", {sen, sdo}, 0);
                chk("abort_rsp_clear", rsp_data, 0);
                @(negedge clk);
                chk("abort_no_done", {done, rsp_valid, cmd_ready}, 3'b001);
                rst = 1'b1;
                exp_bits.delete();
                exp_rsp.delete();
                last_rsp  = '0;
                cmd_valid = 1'b0;
                return;
            end
            exp_sen = k <= N;
            exp_sdo = exp_sen ? exp_bits.pop_front() : 1'b0;
            chk($sformatf("frame_k%0d", k), {sen, sdo}, {exp_sen, exp_sdo});
            sdi = (k >= N + GAP + 1 && k <= N + GAP + 32) ? v.rsp[31 - (k - N - GAP - 1)] : 1'($urandom());
            chk($sformatf("done_k%0d", k), {done, rsp_valid}, {k == v.exp_done, v.rd && k == v.exp_done});
            chk($sformatf("busy_k%0d", k), {cmd_ready, busy}, 2'b01);
            if (k == v.exp_done && v.rd) begin
                chk("rsp_data", rsp_data, exp_rsp.pop_front());
                last_rsp = v.rsp;
            end
        end
        if (!v.rd) chk("rsp_data_hold", rsp_data, last_rsp);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        last_rsp  = '0;
        vt[0] = '{4'hA, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0, 32'h0,         1'b0, 135};
        vt[1] = '{4'h3, 128'hFFFF_0000_AAAA_5555_1234_5678_9ABC_DEF0, 1'b1, 32'hDEAD_BEEF, 1'b0, 167};
        vt[2] = '{4'h0, {128{1'b1}},                                   1'b1, 32'h8000_0001, 1'b0, 167};
        vt[3] = '{4'hF, 128'h0,                                        1'b0, 32'h0,         1'b1, 135};
        vt[4] = '{4'h5, {32{4'hA}},                                    1'b1, 32'h1234_5678, 1'b0, 167};
        vt[5] = '{4'hC, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 1'b0, 32'h0,         1'b0, 135};

        rst = 1'b0; cmd_valid = 1'b1; cmd_instr = 4'h7; cmd_data = '1; cmd_rd = 1'b1; sdi = 1'b0;
        v6 = 1'b0; i6 = '0; d6 = '0; rd6 = 1'b0; sdi6 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {cmd_ready, busy, sen, sdo, done, rsp_valid}, 6'b100000);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_g0", {rdy6, sen6, rsp6}, {1'b1, 1'b0, 8'h0});
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {cmd_ready, sen}, 2'b10);

        for (int i = 0; i < 6; i++) run_cmd(vt[i], i > 0 && vt[i-1].keep, 0);

        run_cmd(vt[1], 1'b0, 60);
        run_cmd(vt[0], 1'b0, 0);

        @(negedge clk);
        chk("g0_ready", rdy6, 1);
        i6 = 4'h9; d6 = {$urandom(), $urandom(), $urandom(), $urandom()}; rd6 = 1'b1; v6 = 1'b1;
        for (int k = 1; k <= N + 9; k++) begin
            @(negedge clk);
            if (k == 1) begin
                v6 = 1'b0;
                chk("g0_first_bit", {sen6, sdo6}, {1'b1, i6[3]});
            end
            sdi6 = (k >= N + 1 && k <= N + 8) ? 8'hA5 >> (7 - (k - N - 1)) & 8'h1 : 1'($urandom());
            if (k == N)     chk("g0_last_sen", sen6, 1);
            if (k == N + 1) chk("g0_sen_off", {sen6, sdo6}, 0);
            if (k == N + 8) chk("g0_no_early_rv", {rv6, done6}, 0);
            if (k == N + 9) begin
                chk("g0_rsp_valid", {rv6, done6}, 2'b11);
                chk("g0_rsp_data", rsp6, 8'hA5);
            end
        end
        @(negedge clk);
        chk("g0_idle", {rdy6, rv6, done6}, 3'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
